// File: rtl/can_bit_timing_pkg.sv
// can_timing_pkg: shared types, default widths and helpers for the CAN bit-timing unit
package can_timing_pkg;
   localparam int BRP_W_D = 10;
   localparam int SEG_W_D = 5;
   localparam int SJW_W_D = 2;
   typedef enum logic [1:0] {SEG_SYNC, SEG_1, SEG_2} seg_t;
   function automatic int tq_per_bit(input int tseg1, input int tseg2);
      return tseg1 + tseg2 + 3;
   endfunction
endpackage

// File: rtl/can_bit_timing_tq_prescaler.sv
// tq_prescaler: divides clk into time-quantum ticks, with a synchronous phase clear
module tq_prescaler #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] brp,
   output logic         tick
);
   logic [W-1:0] pcnt;
   assign tick = en & (pcnt >= brp);
   // count 0..brp; a clear restarts the quantum on the next clock
   always_ff @(posedge clk or posedge rst)
      if (rst) pcnt <= '0;
      else if (en) pcnt <= (clr | tick) ? '0 : pcnt + W'(1);
endmodule

// File: rtl/can_bit_timing.sv
// can_bit_timing: SYNC/SEG1/SEG2 bit timer with hard sync and SJW-limited resynchronisation
module can_bit_timing
   import can_timing_pkg::*;
#(
   parameter int BRP_W = BRP_W_D,
   parameter int SEG_W = SEG_W_D,
   parameter int SJW_W = SJW_W_D
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 rx,
   input  logic                 edge_any,
   input  logic                 hard_sync_req,
   input  logic [BRP_W-1:0]     brp,
   input  logic [SEG_W-1:0]     tseg1,
   input  logic [SEG_W-1:0]     tseg2,
   input  logic [SJW_W-1:0]     sjw,
   output logic                 sample,
   output logic                 sample_bit,
   output logic                 tx_point,
   output logic                 baud,
   output logic                 lock,
   output logic                 glitch,
   output logic signed [SEG_W:0] phase_err
);
   localparam int QW = SEG_W + 1;
   localparam int EW = SEG_W + 2;
   logic [BRP_W-1:0] brp_s, brp_e;
   logic [SEG_W-1:0] tseg1_s, tseg2_s, tseg1_e, tseg2_e;
   logic [SJW_W-1:0] sjw_s, sjw_e;
   logic             cfg_pend;
   seg_t             state;
   logic [QW-1:0]    qcnt, ext, shr, end1, end2;
   logic [EW-1:0]    mag, jw, e_val;
   logic             rxold, trig, tick, edge_q, hard, rs, lock_ok, early, norm, smp_ev, tx_ev;
   // until the first enabled clock after reset the live configuration is used directly
   assign brp_e   = cfg_pend ? brp : brp_s;
   assign tseg1_e = cfg_pend ? tseg1 : tseg1_s;
   assign tseg2_e = cfg_pend ? tseg2 : tseg2_s;
   assign sjw_e   = cfg_pend ? sjw : sjw_s;
   assign edge_q  = en & (rx != rxold) & (edge_any | rxold);
   assign hard    = edge_q & hard_sync_req;
   assign rs      = edge_q & ~hard_sync_req & ~trig;
   assign jw      = EW'(sjw_e) + EW'(1);
   assign mag     = (state == SEG_SYNC) ? '0 :
                    (state == SEG_2) ? EW'(tseg2_e) + EW'(1) - EW'(qcnt) : EW'(qcnt) + EW'(1);
   assign lock_ok = mag <= jw;
   assign e_val   = (state == SEG_2) ? -mag : mag;
   assign early   = rs & (state == SEG_2) & lock_ok;
   assign norm    = ~hard & ~(rs & (state != SEG_SYNC));
   assign end1    = QW'(tseg1_e) + ext;
   assign end2    = QW'(tseg2_e) - shr;
   assign smp_ev  = norm & tick & (state == SEG_1) & (qcnt >= end1);
   assign tx_ev   = early | (norm & tick & (state == SEG_2) & (qcnt >= end2));
   assign baud    = state == SEG_2;
   tq_prescaler #(.W(BRP_W)) u_pre (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (hard | early),
      .brp (brp_e),
      .tick(tick)
   );
   // shadow configuration, reloaded at every bit start so mid-bit changes wait a bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         brp_s    <= '0;
         tseg1_s  <= '0;
         tseg2_s  <= '0;
         sjw_s    <= '0;
         cfg_pend <= 1'b1;
      end else if (en) begin
         cfg_pend <= 1'b0;
         if (cfg_pend | tx_ev) begin
            brp_s   <= brp;
            tseg1_s <= tseg1;
            tseg2_s <= tseg2;
            sjw_s   <= sjw;
         end
      end
   // segment machine: edge corrections take precedence over the normal segment walk
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= SEG_SYNC;
         qcnt       <= '0;
         ext        <= '0;
         shr        <= '0;
         rxold      <= 1'b1;
         trig       <= 1'b0;
         lock       <= 1'b0;
         glitch     <= 1'b0;
         phase_err  <= '0;
         sample     <= 1'b0;
         sample_bit <= 1'b1;
         tx_point   <= 1'b0;
      end else begin
         sample   <= smp_ev;
         tx_point <= tx_ev;
         if (en) begin
            rxold <= rx;
            if (smp_ev) sample_bit <= rx;
            if (edge_q & ~hard_sync_req & trig) glitch <= 1'b1;
            if (hard | rs) begin
               phase_err <= hard ? '0 : e_val[SEG_W:0];
               trig      <= 1'b1;
               lock      <= hard | lock_ok;
            end
            if (hard | early) begin
               state <= SEG_1;
               qcnt  <= '0;
               ext   <= '0;
               shr   <= '0;
            end else if (rs & (state == SEG_1)) begin
               ext <= (mag < jw) ? QW'(mag) : QW'(jw);
               if (tick) qcnt <= qcnt + QW'(1);
            end else if (rs & (state == SEG_2)) begin
               shr <= QW'(jw);
               if (tick) qcnt <= qcnt + QW'(1);
            end else if (tick) begin
               if (state == SEG_SYNC) begin
                  state <= SEG_1;
                  qcnt  <= '0;
               end else if (smp_ev) begin
                  state <= SEG_2;
                  qcnt  <= '0;
                  ext   <= '0;
               end else if (tx_ev) begin
                  state  <= SEG_SYNC;
                  qcnt   <= '0;
                  trig   <= 1'b0;
                  glitch <= 1'b0;
                  shr    <= '0;
               end else qcnt <= qcnt + QW'(1);
            end
         end
      end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed timing checks plus randomized run against a bit-position model
module tb_can_bit_timing;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1, edge_any = 1'b0, hsr = 1'b0;
   logic [9:0] brp = 10'd1;
   logic [4:0] tseg1 = 5'd5, tseg2 = 5'd2;
   logic [1:0] sjw = 2'd1;
   logic sample, sample_bit, tx_point, baud, lock, glitch;
   logic signed [5:0] phase_err;
   int checks = 0, errors = 0, cyc = 0;
   bit chk_on = 1'b0;

   can_bit_timing dut (
      .clk(clk), .rst(rst), .en(en), .rx(rx), .edge_any(edge_any), .hard_sync_req(hsr),
      .brp(brp), .tseg1(tseg1), .tseg2(tseg2), .sjw(sjw),
      .sample(sample), .sample_bit(sample_bit), .tx_point(tx_point), .baud(baud),
      .lock(lock), .glitch(glitch), .phase_err(phase_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // model: position of the current tq inside the bit (0 = SYNC, then SEG1, then SEG2)
   int m_pos, m_pc, m_ext, m_shr, m_pe, m_b, m_t1, m_t2, m_sj;
   bit m_trig, m_gl, m_lock, m_sb, m_rxo, m_pend, m_sp, m_tp, m_baud;
   always @(posedge clk or posedge rst) begin : model
      int b, t1, t2, sj, s1, q, m;
      bit tick, edg, cl, nrm;
      if (rst) begin
         m_pos = 0; m_pc = 0; m_ext = 0; m_shr = 0; m_pe = 0;
         m_trig = 0; m_gl = 0; m_lock = 0; m_sb = 1; m_rxo = 1; m_pend = 1;
         m_sp = 0; m_tp = 0; m_baud = 0;
      end else begin
         m_sp = 0; m_tp = 0;
         if (en) begin
            b  = m_pend ? int'(brp) : m_b;
            t1 = m_pend ? int'(tseg1) : m_t1;
            t2 = m_pend ? int'(tseg2) : m_t2;
            sj = m_pend ? int'(sjw) : m_sj;
            s1 = t1 + 1 + m_ext;
            q = (m_pos == 0) ? 0 : (m_pos <= s1) ? m_pos - 1 : m_pos - 1 - s1;
            tick = m_pc >= b;
            edg = (rx != m_rxo) && (edge_any || m_rxo);
            cl = 0; nrm = 1;
            if (edg && hsr) begin
               m_pos = 1; cl = 1; nrm = 0; m_ext = 0; m_shr = 0;
               m_trig = 1; m_lock = 1; m_pe = 0;
            end else if (edg && m_trig) m_gl = 1;
            else if (edg) begin
               m_trig = 1;
               if (m_pos == 0) begin
                  m_pe = 0; m_lock = 1;
               end else if (m_pos <= s1) begin
                  m = q + 1;
                  m_ext = (m < sj + 1) ? m : sj + 1;
                  m_pe = m; m_lock = (m <= sj + 1); nrm = 0;
                  if (tick) m_pos++;
               end else begin
                  m = t2 + 1 - q;
                  m_pe = -m; m_lock = (m <= sj + 1); nrm = 0;
                  if (m_lock) begin
                     m_tp = 1; m_pos = 1; cl = 1; m_ext = 0; m_shr = 0;
                  end else begin
                     m_shr = sj + 1;
                     if (tick) m_pos++;
                  end
               end
            end
            if (nrm && tick) begin
               if (m_pos == 0) m_pos = 1;
               else if (m_pos <= s1) begin
                  if (q >= t1 + m_ext) begin m_sp = 1; m_sb = rx; end
                  m_pos++;
               end else if (q >= t2 - m_shr) begin
                  m_tp = 1; m_pos = 0; m_trig = 0; m_gl = 0; m_shr = 0; m_ext = 0;
               end else m_pos++;
            end
            m_pc = (cl || tick) ? 0 : m_pc + 1;
            if (m_pend || m_tp) begin m_b = brp; m_t1 = tseg1; m_t2 = tseg2; m_sj = sjw; end
            m_pend = 0;
            m_rxo = rx;
         end
         m_baud = (m_pos > m_t1 + 1 + m_ext);
      end
   end

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d cyc=%0d", n, act, exp, cyc);
      end
   endtask

   always @(negedge clk) if (chk_on) begin
      chk("sample", sample, m_sp);
      chk("tx_point", tx_point, m_tp);
      chk("sample_bit", sample_bit, m_sb);
      chk("baud", baud, m_baud);
      chk("lock", lock, m_lock);
      chk("glitch", glitch, m_gl);
      chk("phase_err", phase_err, m_pe);
   end

   task automatic drive_at(input int c);
      while (cyc < c) begin @(posedge clk); #2; end
   endtask

   task automatic at_neg(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic wait_ev(input bit smp, output int at);
      at = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (smp ? sample : tx_point) begin at = cyc; break; end
      end
      if (at < 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout cyc=%0d", smp ? "sample" : "tx_point", cyc);
      end
   endtask

   int t0, t1, t2, t3, t4, t5, t6, t7, s, e;
   initial begin
      en = 1'b1;
      repeat (2) @(posedge clk);
      #2 chk_on = 1'b1;
      at_neg(cyc + 1);
      chk("rst_sample_bit", sample_bit, 1);
      chk("rst_tx_point", tx_point, 0);
      chk("rst_phase_err", phase_err, 0);
      @(posedge clk); #2 rst = 1'b0;
      // nominal bit: 20 clocks, sample 14 after tx_point
      wait_ev(0, t0);
      wait_ev(1, s);
      chk("nom_smp_ofs", s - t0, 14);
      chk("nom_baud", baud, 1);
      wait_ev(0, t1);
      chk("nom_period", t1 - t0, 20);
      chk("nom_baud_tx", baud, 0);
      // late edge at SEG1 qcnt=2: e=+3, ext=2
      drive_at(t1 + 6); rx = 1'b0;
      at_neg(t1 + 7);
      chk("late_pe", phase_err, 3);
      chk("late_lock", lock, 0);
      wait_ev(0, t2);
      chk("late_period", t2 - t1, 24);
      // early edge at SEG2 qcnt=2: e=-1, immediate tx_point
      edge_any = 1'b1;
      drive_at(t2 + 18); rx = 1'b1;
      wait_ev(0, t3);
      chk("early_tx", t3 - t2, 19);
      chk("early_pe", phase_err, -1);
      chk("early_lock", lock, 1);
      // second edge 2 tq later in the same bit
      drive_at(t3 + 3); rx = 1'b0;
      at_neg(t3 + 4);
      chk("glitch_set", glitch, 1);
      chk("glitch_pe", phase_err, -1);
      wait_ev(0, t4);
      chk("glitch_period", t4 - t3, 18);
      chk("glitch_clr", glitch, 0);
      // hard sync on a falling edge while idle
      @(posedge clk); #2 edge_any = 1'b0; hsr = 1'b1; rx = 1'b1;
      drive_at(cyc + 3); rx = 1'b0; e = cyc + 1;
      at_neg(e);
      chk("hs_lock", lock, 1);
      chk("hs_pe", phase_err, 0);
      @(posedge clk); #2 hsr = 1'b0;
      wait_ev(1, s);
      chk("hs_smp", s - e, 12);
      chk("hs_sample_bit", sample_bit, 0);
      // asynchronous reset mid-bit
      wait_ev(0, t5);
      drive_at(t5 + 5); rst = 1'b1; rx = 1'b1;
      #1;
      chk("arst_lock", lock, 0);
      chk("arst_sample_bit", sample_bit, 1);
      chk("arst_baud", baud, 0);
      @(posedge clk); #2 rst = 1'b0;
      // mid-bit tseg1 change takes effect on the next bit
      wait_ev(0, t5);
      drive_at(t5 + 5); tseg1 = 5'd3;
      wait_ev(0, t6);
      chk("cfg_old_period", t6 - t5, 20);
      wait_ev(0, t7);
      chk("cfg_new_period", t7 - t6, 16);
      // randomized run against the model
      for (int i = 0; i < 15000; i++) begin
         @(posedge clk); #2;
         rst = ($urandom_range(0, 999) == 0);
         en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 11) == 0) rx = ~rx;
         hsr = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) == 0) edge_any = ~edge_any;
         if ($urandom_range(0, 199) == 0) begin
            sjw = 2'($urandom_range(0, 3));
            tseg2 = 5'(sjw) + 5'($urandom_range(0, 4));
            tseg1 = 5'($urandom_range(1, 10));
            brp = 10'($urandom_range(0, 3));
         end
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
